genius_seq_mem: RTL and testbench

- Sequence-memory responder on the far side of the game controller's mem_rd/mem_wr interface.
- Holds the Genius colour sequence: DEPTH entries of 2-bit colour codes (0 green, 1 red, 2 yellow, 3 blue).
- Services controller reads and writes with fixed one-cycle read latency.
- Appends a pseudo-random colour per level from an internal LFSR; clears itself via a multi-cycle scrub FSM.

---
 rtl/genius_seq_mem.sv | 125 ++++++++++++
 tb/tb_genius_seq_mem.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/genius_seq_mem.sv
// Sequence memory for the Genius game controller: colour storage, LFSR-driven
// appends, one-cycle reads and a DEPTH-cycle scrub state machine.
module genius_seq_mem #(
  parameter int          DEPTH  = 32,
  parameter logic [15:0] SEED   = 16'hACE1,
  localparam int         ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        wr_data,
  input  logic              append,
  input  logic              clear,
  output logic [1:0]        rd_data,
  output logic              rd_valid,
  output logic              append_ack,
  output logic [1:0]        last_color,
  output logic [ADDR_W:0]   length,
  output logic              full,
  output logic              busy,
  output logic              err,
  output logic              state_dbg
);

  // Handshake: mem_rd, mem_wr, append and clear are single-cycle requests with
  // no ready; each is either accepted (rd_valid / append_ack the next cycle)
  // or rejected (err the next cycle). Nothing is ever queued or retried.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IX = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [15:0]       lfsr;
  logic [1:0]        mem [DEPTH];

  logic in_range;
  logic do_clear, do_append, do_wr, do_rd, err_d;

  assign full      = (length == DEPTH_L);
  assign busy      = (state_q == S_CLEAR);
  assign state_dbg = state_q;
  assign in_range  = ({1'b0, addr} < length);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      lfsr       <= SEED;
      length     <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      append_ack <= 1'b0;
      last_color <= '0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      rd_valid   <= do_rd;
      append_ack <= do_append;
      err        <= err_d;
      if (do_clear) begin
        ptr_q  <= '0;
        length <= '0;
      end else if (state_q == S_CLEAR) begin
        ptr_q <= ptr_q + 1'b1;
      end
      if (do_append) begin
        length     <= length + 1'b1;
        last_color <= lfsr[1:0];
      end
      if (do_rd) rd_data <= in_range ? mem[addr] : 2'b00;
    end
  end

  // Storage is deliberately not reset; the scrub pass is the only way to zero it.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR)  mem[ptr_q] <= 2'b00;
    else if (do_append)      mem[length[ADDR_W-1:0]] <= lfsr[1:0];
    else if (do_wr)          mem[addr] <= wr_data;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clear) state_d = S_CLEAR;
      S_CLEAR: if (ptr_q == LAST_IX) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request arbitration: clear > append > mem_wr > mem_rd; losers flag err,
  // except when clear wins, which swallows the others silently.
  always_comb begin
    do_clear  = 1'b0;
    do_append = 1'b0;
    do_wr     = 1'b0;
    do_rd     = 1'b0;
    err_d     = 1'b0;
    if (state_q == S_CLEAR) begin
      err_d = append | mem_wr | mem_rd;
    end else if (clear) begin
      do_clear = 1'b1;
    end else if (append) begin
      do_append = !full;
      err_d     = full | mem_wr | mem_rd;
    end else if (mem_wr) begin
      do_wr = in_range;
      err_d = !in_range | mem_rd;
    end else if (mem_rd) begin
      do_rd = 1'b1;
      err_d = !in_range;
    end
  end

endmodule

// File: tb/tb_genius_seq_mem.sv
// Bench for genius_seq_mem: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the sequence memory.
module tb_genius_seq_mem;

  localparam int          DEPTH  = 32;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          ADDR_W = $clog2(DEPTH);

  logic              clk, rst_;
  logic              mem_rd, mem_wr, append, clear;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        wr_data;
  logic [1:0]        rd_data, last_color;
  logic              rd_valid, append_ack, full, busy, err, state_dbg;
  logic [ADDR_W:0]   length;

  int checks = 0;
  int errors = 0;
  int acks   = 0;

  genius_seq_mem #(.DEPTH(DEPTH), .SEED(SEED)) dut (
    .clk(clk), .rst_(rst_), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr),
    .wr_data(wr_data), .append(append), .clear(clear), .rd_data(rd_data),
    .rd_valid(rd_valid), .append_ack(append_ack), .last_color(last_color),
    .length(length), .full(full), .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  // Reference model: the sequence as a plain array plus a length, the scrub as
  // a countdown of remaining busy cycles.
  logic [15:0] m_lfsr;
  int          m_seq [DEPTH];
  int          m_len, m_clear_left, m_rdd, m_last;
  bit          m_rv, m_ack, m_err;
  int          m_col;

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      m_lfsr = SEED; m_len = 0; m_clear_left = 0;
      m_rv = 0; m_rdd = 0; m_ack = 0; m_last = 0; m_err = 0;
    end else begin
      m_col = int'(m_lfsr[1:0]);
      m_rv = 0; m_ack = 0; m_err = 0;
      if (m_clear_left > 0) begin
        m_err = append || mem_wr || mem_rd;
        m_clear_left--;
      end else if (clear) begin
        m_clear_left = DEPTH;
        m_len = 0;
        foreach (m_seq[i]) m_seq[i] = 0;
      end else if (append) begin
        if (m_len < DEPTH) begin
          m_seq[m_len] = m_col; m_last = m_col; m_len++; m_ack = 1;
        end else m_err = 1;
        if (mem_wr || mem_rd) m_err = 1;
      end else if (mem_wr) begin
        if (int'(addr) < m_len) m_seq[addr] = int'(wr_data);
        else m_err = 1;
        if (mem_rd) m_err = 1;
      end else if (mem_rd) begin
        m_rv = 1;
        if (int'(addr) < m_len) m_rdd = m_seq[addr];
        else begin m_rdd = 0; m_err = 1; end
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  // Scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("rd_valid",   32'(rd_valid),   32'(m_rv));
    check("rd_data",    32'(rd_data),    32'(m_rdd));
    check("append_ack", 32'(append_ack), 32'(m_ack));
    check("err",        32'(err),        32'(m_err));
    check("length",     32'(length),     32'(m_len));
    check("full",       32'(full),       32'(m_len == DEPTH));
    check("busy",       32'(busy),       32'(m_clear_left > 0));
    check("last_color", 32'(last_color), 32'(m_last));
  endtask

  // Drivers: apply one cycle of requests, then check at the following negedge.
  task automatic op(input bit rd, input bit wr, input int a, input int wd,
                    input bit ap, input bit cl);
    mem_rd = rd; mem_wr = wr; addr = ADDR_W'(a); wr_data = 2'(wd);
    append = ap; clear = cl;
    @(negedge clk);
    if (append_ack) acks++;
    check_outputs();
  endtask

  task automatic idle();
    op(0, 0, 0, 0, 0, 0);
  endtask

  int n;

  initial begin
    rst_ = 1'b0;
    mem_rd = 0; mem_wr = 0; addr = '0; wr_data = '0; append = 0; clear = 0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_ = 1'b1;

    // Four appends, then read them back
    for (int i = 0; i < 4; i++) op(0, 0, 0, 0, 1, 0);
    check("ack_count_4", 32'(acks), 32'd4);
    check("last_color_4th", 32'(last_color), 32'(m_seq[3]));
    idle();
    for (int i = 0; i < 4; i++) op(1, 0, i, 0, 0, 0);
    idle();

    // In-range write, out-of-range write and read
    op(0, 1, 2, 3, 0, 0);
    op(1, 0, 2, 0, 0, 0);
    check("rd_after_wr", 32'(rd_data), 32'd3);
    op(0, 1, 5, 1, 0, 0);
    check("wr_oob_err", 32'(err), 32'd1);
    op(1, 0, 5, 0, 0, 0);
    check("rd_oob_data", 32'(rd_data), 32'd0);
    idle();

    // Fill and overflow
    while (length < (ADDR_W + 1)'(DEPTH) && n < 100) begin n++; op(0, 0, 0, 0, 1, 0); end
    check("full_flag", 32'(full), 32'd1);
    acks = 0;
    op(0, 0, 0, 0, 1, 0);
    check("overflow_err", 32'(err), 32'd1);
    check("overflow_no_ack", 32'(acks), 32'd0);
    check("overflow_len", 32'(length), 32'(DEPTH));

    // Scrub with reads during busy
    op(0, 0, 0, 0, 0, 1);
    check("len_after_clear", 32'(length), 32'd0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      op(n < 4, 0, 0, 0, 0, n == 8);
    end
    check("busy_cycles", 32'(n), 32'(DEPTH));
    op(0, 0, 0, 0, 1, 0);
    op(1, 0, 0, 0, 0, 0);
    check("rd_new_color", 32'(rd_data), 32'(m_last));

    // Simultaneous requests, then back-to-back reads
    for (int i = 0; i < 3; i++) op(0, 0, 0, 0, 1, 0);
    op(1, 1, 0, 2, 1, 0);
    check("combo_err", 32'(err), 32'd1);
    for (int i = 0; i < 4; i++) op(1, 0, i, 0, 0, 0);
    idle();

    // Reset in the middle of a scrub
    op(0, 0, 0, 0, 0, 1);
    repeat (9) idle();
    rst_ = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_length", 32'(length), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    op(0, 0, 0, 0, 1, 0);
    check("post_rst_ack", 32'(append_ack), 32'd1);
    check("post_rst_seed_color", 32'(last_color), 32'(SEED[1:0]));

    // Random traffic
    for (int i = 0; i < 1500; i++)
      op($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
         int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 3)),
         $urandom_range(0, 2) == 0, $urandom_range(0, 79) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
